// File: rtl/mul_pkg.sv
// Shared types and elaboration helpers for the sequential digit multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  // Number of compute cycles: one per DIGIT-bit slice of the multiplier.
  function automatic int mul_steps(input int width, input int digit);
    return width / digit;
  endfunction

  // Counter width that still works when there is only a single step.
  function automatic int mul_cnt_width(input int steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

endpackage

// File: rtl/mul_digit.sv
// Combinational WIDTH x DIGIT partial-product multiplier.
module mul_digit #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic [WIDTH-1:0]       a,
  input  logic [DIGIT-1:0]       d,
  output logic [WIDTH+DIGIT-1:0] p
);

  // Operands widened to the full product width so no bit is lost.
  assign p = (WIDTH+DIGIT)'(a) * (WIDTH+DIGIT)'(d);

endmodule

// File: rtl/mul_seq.sv
// Sequential unsigned multiplier: retires DIGIT bits of b per clock using one
// WIDTH x DIGIT partial-product multiplier and a shift-add accumulator.
module mul_seq
  import mul_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] r,
  output logic               busy
);

  localparam int STEPS = mul_steps(WIDTH, DIGIT);
  localparam int CW    = mul_cnt_width(STEPS);
  localparam int PW    = WIDTH + DIGIT;
  localparam int RW    = 2 * WIDTH;
  localparam int SW    = $clog2(RW) + 1;

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("mul_seq: WIDTH must be >= 2 and DIGIT >= 1 must divide WIDTH");
    end
  endgenerate

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; in_ready and out_valid are decoded from state only, so neither
  // depends combinationally on any input.

  mul_state_e      state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [RW-1:0]    acc_q;
  logic [RW-1:0]    r_q;

  logic [PW-1:0]    pp;
  logic [SW-1:0]    shamt;
  logic [RW-1:0]    acc_next;
  logic             last_step;

  // b is shifted right each step so the current digit is always the low slice.
  mul_digit #(
    .WIDTH(WIDTH),
    .DIGIT(DIGIT)
  ) u_digit (
    .a(a_q),
    .d(b_sh_q[DIGIT-1:0]),
    .p(pp)
  );

  assign shamt     = SW'(cnt_q) * SW'(DIGIT);
  assign acc_next  = acc_q + (RW'(pp) << shamt);
  assign last_step = (cnt_q == CW'(STEPS - 1));

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (last_step) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q    <= a;
            b_sh_q <= b;
            acc_q  <= '0;
            cnt_q  <= '0;
          end
        end
        RUN: begin
          acc_q  <= acc_next;
          b_sh_q <= b_sh_q >> DIGIT;
          if (last_step) begin
            cnt_q <= '0;
            r_q   <= acc_next;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // r keeps the last completed product between results.
  assign r = r_q;

endmodule

// File: tb/tb_mul_seq.sv
// Bench for mul_seq: four parameter configurations, directed cases and
// randomized operands checked every cycle against a transaction-level model.
module tb_mul_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] a_drv = '0;
  logic [15:0] b_drv = '0;
  logic        in_valid_drv = 1'b0;
  logic        out_ready_drv = 1'b1;
  int          sel = 0;
  bit          chk_en = 1'b0;
  bit          rand_or = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int e0 = 0;

  always #5 clk = ~clk;

  logic [3:0]  iv, ordy, irdy, ovld, bsy;
  logic [15:0] r0;
  logic [7:0]  r1;
  logic [31:0] r2;
  logic [15:0] r3;
  logic        irdy_o, ovld_o, bsy_o;
  logic [31:0] r_o;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      iv[i]   = in_valid_drv && (sel == i);
      ordy[i] = out_ready_drv && (sel == i);
    end
  end

  mul_seq #(.WIDTH(8), .DIGIT(2)) u_w8d2 (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(irdy[0]),
    .a(a_drv[7:0]), .b(b_drv[7:0]), .out_valid(ovld[0]), .out_ready(ordy[0]),
    .r(r0), .busy(bsy[0]));

  mul_seq #(.WIDTH(4), .DIGIT(1)) u_w4d1 (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(irdy[1]),
    .a(a_drv[3:0]), .b(b_drv[3:0]), .out_valid(ovld[1]), .out_ready(ordy[1]),
    .r(r1), .busy(bsy[1]));

  mul_seq #(.WIDTH(16), .DIGIT(4)) u_w16d4 (
    .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(irdy[2]),
    .a(a_drv), .b(b_drv), .out_valid(ovld[2]), .out_ready(ordy[2]),
    .r(r2), .busy(bsy[2]));

  mul_seq #(.WIDTH(8), .DIGIT(8)) u_w8d8 (
    .clk(clk), .reset(reset), .in_valid(iv[3]), .in_ready(irdy[3]),
    .a(a_drv[7:0]), .b(b_drv[7:0]), .out_valid(ovld[3]), .out_ready(ordy[3]),
    .r(r3), .busy(bsy[3]));

  always_comb begin
    irdy_o = irdy[0];
    ovld_o = ovld[0];
    bsy_o  = bsy[0];
    r_o    = {16'b0, r0};
    case (sel)
      1: begin irdy_o = irdy[1]; ovld_o = ovld[1]; bsy_o = bsy[1]; r_o = {24'b0, r1}; end
      2: begin irdy_o = irdy[2]; ovld_o = ovld[2]; bsy_o = bsy[2]; r_o = r2; end
      3: begin irdy_o = irdy[3]; ovld_o = ovld[3]; bsy_o = bsy[3]; r_o = {16'b0, r3}; end
      default: ;
    endcase
  end

  // ---------------- reference model (transaction level) ----------------
  int          steps_tab[4] = '{4, 4, 4, 1};
  int          width_tab[4] = '{8, 4, 16, 8};
  bit          m_pending = 1'b0;
  bit          m_have = 1'b0;
  int          m_remain = 0;
  logic [31:0] m_last = '0;
  logic [31:0] exp_q[$];
  logic [31:0] done_r_q[$];
  int          done_cyc_q[$];

  function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y,
                                          input int w);
    logic [15:0]     mask;
    longint unsigned p;
    mask = 16'((32'h1 << w) - 1);
    p = longint'(x & mask) * longint'(y & mask);
    return p[31:0];
  endfunction

  always @(posedge clk) begin
    if (!reset && ovld_o && out_ready_drv) begin
      done_r_q.push_back(r_o);
      done_cyc_q.push_back(cyc);
    end
    cyc = cyc + 1;
    if (reset) begin
      m_pending = 1'b0;
      m_have    = 1'b0;
      m_remain  = 0;
      m_last    = '0;
      exp_q.delete();
    end else if (m_pending) begin
      m_remain = m_remain - 1;
      if (m_remain == 0) begin
        m_pending = 1'b0;
        m_have    = 1'b1;
        m_last    = exp_q.pop_front();
      end
    end else if (m_have) begin
      if (out_ready_drv) m_have = 1'b0;
    end else if (in_valid_drv) begin
      m_pending = 1'b1;
      m_remain  = steps_tab[sel];
      exp_q.push_back(ref_mul(a_drv, b_drv, width_tab[sel]));
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (sel %0d cycle %0d)", name, act, exp, sel, cyc);
    end
  endtask

  task automatic note_timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out (sel %0d cycle %0d)", name, sel, cyc);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", {31'b0, irdy_o}, {31'b0, !(m_pending || m_have)});
      check("out_valid", {31'b0, ovld_o}, {31'b0, m_have});
      check("busy", {31'b0, bsy_o}, {31'b0, (m_pending || m_have)});
      check("r", r_o, m_last);
    end
  end

  always @(negedge clk) begin
    if (rand_or) out_ready_drv = ($urandom_range(0, 3) != 0);
  end

  // ---------------- driver tasks ----------------
  task automatic select_cfg(input int s);
    @(negedge clk);
    chk_en = 1'b0;
    reset = 1'b1;
    sel = s;
    in_valid_drv = 1'b0;
    out_ready_drv = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    check("reset_in_ready", {31'b0, irdy_o}, 32'd1);
    check("reset_out_valid", {31'b0, ovld_o}, 32'd0);
    check("reset_busy", {31'b0, bsy_o}, 32'd0);
    check("reset_r", r_o, 32'd0);
  endtask

  task automatic send(input logic [15:0] x, input logic [15:0] y);
    int n;
    n = 0;
    @(negedge clk);
    while (!irdy_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!irdy_o) note_timeout("send_wait_ready");
    a_drv = x;
    b_drv = y;
    in_valid_drv = 1'b1;
    @(posedge clk);
    #1 e0 = cyc;
    @(negedge clk);
    in_valid_drv = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    int n;
    n = 0;
    lat = -1;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (ovld_o) break;
    end
    if (ovld_o) lat = cyc - e0;
    else note_timeout("wait_out_valid");
  endtask

  task automatic run_directed(input logic [15:0] x, input logic [15:0] y,
                              input logic [31:0] exp_r, input int exp_lat,
                              input string name);
    int lat;
    out_ready_drv = 1'b1;
    send(x, y);
    wait_valid(lat);
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_r"}, r_o, exp_r);
    @(negedge clk);
    check({name, "_ready_after"}, {31'b0, irdy_o}, 32'd1);
    check({name, "_valid_after"}, {31'b0, ovld_o}, 32'd0);
  endtask

  task automatic run_random(input int n);
    int k;
    logic [15:0] x, y;
    rand_or = 1'b1;
    repeat (n) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      x = 16'($urandom_range(0, 65535));
      y = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 9) == 0) x = 16'hFFFF;
      if ($urandom_range(0, 9) == 0) y = 16'hFFFF;
      if ($urandom_range(0, 19) == 0) y = 16'h0000;
      send(x, y);
    end
    @(negedge clk);
    rand_or = 1'b0;
    out_ready_drv = 1'b1;
    k = 0;
    while ((m_pending || m_have) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (m_pending || m_have) note_timeout("random_drain");
  endtask

  // ---------------- test sequence ----------------
  logic [15:0] sx[3] = '{16'd6, 16'd100, 16'd1};
  logic [15:0] sy[3] = '{16'd7, 16'd100, 16'd255};

  initial begin
    int n;
    select_cfg(0);
    run_directed(16'd13, 16'd11, 32'd143, 4, "basic");
    run_directed(16'd255, 16'd255, 32'd65025, 4, "max8");
    run_directed(16'd0, 16'd200, 32'd0, 4, "zero_a");

    // Backpressure holds the result.
    out_ready_drv = 1'b0;
    send(16'd200, 16'd3);
    wait_valid(n);
    check("bp_latency", n, 32'd4);
    repeat (6) begin
      @(negedge clk);
      check("bp_valid", {31'b0, ovld_o}, 32'd1);
      check("bp_r", r_o, 32'd600);
      check("bp_in_ready", {31'b0, irdy_o}, 32'd0);
    end
    out_ready_drv = 1'b1;
    @(negedge clk);
    check("bp_release_valid", {31'b0, ovld_o}, 32'd0);
    check("bp_release_ready", {31'b0, irdy_o}, 32'd1);

    // Reset in the second RUN cycle discards the product.
    send(16'd7, 16'd9);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrun_in_ready", {31'b0, irdy_o}, 32'd1);
    check("midrun_out_valid", {31'b0, ovld_o}, 32'd0);
    check("midrun_busy", {31'b0, bsy_o}, 32'd0);
    check("midrun_r", r_o, 32'd0);
    run_directed(16'd5, 16'd6, 32'd30, 4, "after_reset");

    // Streaming with in_valid held high.
    done_r_q.delete();
    done_cyc_q.delete();
    out_ready_drv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      @(negedge clk);
      while (!irdy_o && n < 50) begin
        @(negedge clk);
        n++;
      end
      a_drv = sx[i];
      b_drv = sy[i];
      in_valid_drv = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid_drv = 1'b0;
    n = 0;
    while (done_r_q.size() < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (done_r_q.size() < 3) begin
      note_timeout("stream_results");
    end else begin
      check("stream_r0", done_r_q[0], 32'd42);
      check("stream_r1", done_r_q[1], 32'd10000);
      check("stream_r2", done_r_q[2], 32'd255);
      check("stream_gap01", done_cyc_q[1] - done_cyc_q[0], 32'd6);
      check("stream_gap12", done_cyc_q[2] - done_cyc_q[1], 32'd6);
    end
    run_random(500);

    select_cfg(1);
    run_directed(16'd15, 16'd15, 32'd225, 4, "w4d1_max");
    run_directed(16'd9, 16'd6, 32'd54, 4, "w4d1_mid");
    run_random(1000);

    select_cfg(2);
    run_directed(16'hFFFF, 16'hFFFF, 32'd4294836225, 4, "w16d4_max");
    run_directed(16'd1234, 16'd5678, 32'd7006652, 4, "w16d4_mid");
    run_random(1000);

    select_cfg(3);
    run_directed(16'd13, 16'd11, 32'd143, 1, "w8d8_basic");
    run_directed(16'd255, 16'd255, 32'd65025, 1, "w8d8_max");
    run_random(1000);

    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mul_seq.md
Name: mul_seq

Overview:
Parametrised sequential unsigned multiplier. It computes r = a * b for WIDTH-bit operands by retiring DIGIT bits of b per clock. Each step uses one WIDTH x DIGIT partial-product multiplier plus a shift-add. It generalises the team's fixed-width combinational digit-composed multipliers into a multi-cycle unit with valid/ready handshakes on input and output, for use in datapaths where area matters more than latency.

Parameters:
WIDTH, 8, operand width in bits; must be >= 2.
DIGIT, 2, bits of b consumed per step; must be >= 1 and must divide WIDTH exactly (elaboration-time assertion).
STEPS, WIDTH/DIGIT, derived localparam; number of compute cycles. Not overridable.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  operands a, b valid
in_ready  output  1  block can accept operands
a  input  WIDTH  multiplicand, unsigned
b  input  WIDTH  multiplier, unsigned
out_valid  output  1  r holds a completed product
out_ready  input  1  consumer accepts r
r  output  2*WIDTH  product, unsigned
busy  output  1  high in RUN or DONE

Behaviour:
- States: IDLE, RUN, DONE. The step counter ranges 0..STEPS-1.
- Reset (clk edge with reset=1): state=IDLE, counter=0, accumulator=0.
  - Outputs after reset: in_ready=1, out_valid=0, busy=0, r=0.
- Reset wins over every other event, including mid-RUN and during DONE. Any in-flight product is discarded with no out_valid pulse.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch a and b, clear the accumulator, counter=0, go to RUN.
  - With in_valid=0: stay in IDLE.
- RUN:
  - in_ready=0.
  - Each edge adds a * b[DIGIT*k +: DIGIT], shifted left by DIGIT*k, to the accumulator (k = counter), then increments the counter.
  - Invariant after step k: acc == a * (b mod 2^(DIGIT*(k+1))).
  - The accumulator is 2*WIDTH bits and never overflows; no truncation is permitted in any intermediate.
  - The edge that completes step STEPS-1 moves to DONE.
- Latency:
  - Handshake accepted at edge E0; out_valid=1 from edge E0+STEPS.
  - Defaults give 4 cycles. WIDTH=8, DIGIT=8 gives 1 cycle.
- DONE:
  - out_valid=1; r = final accumulator.
  - r and out_valid are stable until an edge with out_ready=1, after which state=IDLE and out_valid=0.
  - in_ready=0 in DONE, so there is no overlap: the earliest next accept is the edge after the output handshake.
- r outside DONE: holds the last completed product (0 after reset). Consumers must qualify r with out_valid.
- Operand changes on a and b while not in IDLE are ignored.
- in_valid held high continuously gives back-to-back operation with a throughput of one product per STEPS+2 cycles when out_ready=1.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.

Decomposition:
- Package mul_pkg:
  - typedef enum for state (IDLE, RUN, DONE).
  - A function computing the steps count from WIDTH and DIGIT.
- One sub-module, mul_digit (params WIDTH, DIGIT):
  - Combinational a[WIDTH-1:0] * d[DIGIT-1:0] -> p[WIDTH+DIGIT-1:0].
  - This is the parametrised generalisation of the team's fixed 2-bit digit multiplier.
  - Instantiated once; it is the only multiplier in the datapath.

Test Plan:
1. Defaults; a=13, b=11, in_valid pulse, out_ready=1 -> out_valid rises exactly 4 edges after accept; r=143; in_ready=1 one cycle later.
2. Defaults; a=255, b=255 -> r=65025 (0xFE01). Also a=0, b=200 -> r=0, with the same latency as case 1.
3. Backpressure: a=200, b=3, out_ready=0 for 6 cycles after out_valid -> r=600 and out_valid stay stable, in_ready=0 throughout; out_ready=1 -> IDLE the following cycle.
4. Reset mid-RUN: accept a=7, b=9, assert reset on the 2nd RUN cycle -> next cycle in_ready=1, out_valid=0, busy=0, r=0. A fresh a=5, b=6 then gives r=30.
5. Streaming: in_valid held high with 3 operand pairs, out_ready=1 -> products 6*7=42, 100*100=10000, 1*255=255 in order, 6 cycles apart.
6. Parameter sweep: WIDTH=4/DIGIT=1 gives 15*15=225 after 4 steps; WIDTH=16/DIGIT=4 gives 65535*65535=4294836225 after 4 steps; WIDTH=8/DIGIT=8 gives 1-step latency. Each configuration also runs 1000 random pairs checked against a reference a*b.
